// File: rtl/wbu_ascii_cmd_decoder.sv
// ASCII command parser for the UART debug link: turns 'A'/'D' hex fields plus 'R'/'W'
// into single bus commands over a valid/ready handshake towards the wishbone master.
module wbu_ascii_cmd_decoder #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_rx_stb,
  input  logic [7:0]    i_rx_data,
  output logic          o_cmd_valid,
  input  logic          i_cmd_ready,
  output logic          o_cmd_we,
  output logic [AW-1:0] o_cmd_addr,
  output logic [DW-1:0] o_cmd_data,
  output logic          o_err,
  output logic          o_overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_D  = 8'h44;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_X  = 8'h58;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  state_e          state_q, state_d;
  logic            addr_ok_q, addr_ok_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            cmd_we_q, cmd_we_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]   cmd_data_q, cmd_data_d;
  logic            err_q, err_d;
  logic            overrun_q, overrun_d;

  logic            is_hex;
  logic [3:0]      nibble;
  logic            issue;
  logic            issue_we;

  // Only '0'-'9' and lowercase 'a'-'f' are digits; uppercase letters are commands or illegal.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = i_rx_data[3:0];
    end else if (i_rx_data >= 8'h61 && i_rx_data <= 8'h66) begin
      is_hex = 1'b1;
      nibble = i_rx_data[3:0] + 4'd9;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    addr_ok_d   = addr_ok_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    err_d       = 1'b0;
    overrun_d   = 1'b0;
    issue       = 1'b0;
    issue_we    = 1'b0;

    if (cmd_valid_q && i_cmd_ready) begin
      cmd_valid_d = 1'b0;
    end

    if (i_rx_stb) begin
      if (is_hex) begin
        case (state_q)
          ADDR:    addr_d = {addr_q[AW-5:0], nibble};
          DATA:    data_d = {data_q[DW-5:0], nibble};
          default: err_d  = 1'b1;
        endcase
      end else begin
        case (i_rx_data)
          CH_A: begin
            addr_d    = '0;
            addr_ok_d = 1'b1;
            state_d   = ADDR;
          end
          CH_D: begin
            if (addr_ok_q) begin
              data_d  = '0;
              state_d = DATA;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          CH_R, CH_W: begin
            state_d = IDLE;
            if (addr_ok_q) begin
              issue    = 1'b1;
              issue_we = (i_rx_data == CH_W);
              addr_d   = addr_q + AW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
          CH_X, CH_CR, CH_LF: begin
            state_d   = IDLE;
            addr_ok_d = 1'b0;
          end
          default: begin
            err_d     = 1'b1;
            state_d   = IDLE;
            addr_ok_d = 1'b0;
          end
        endcase
      end
    end

    // A new command may replace one being accepted this cycle; otherwise it is dropped.
    if (issue) begin
      if (!cmd_valid_q || i_cmd_ready) begin
        cmd_valid_d = 1'b1;
        cmd_we_d    = issue_we;
        cmd_addr_d  = addr_q;
        cmd_data_d  = data_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_ok_q   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_ok_q   <= addr_ok_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd_we    = cmd_we_q;
  assign o_cmd_addr  = cmd_addr_q;
  assign o_cmd_data  = cmd_data_q;
  assign o_err       = err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_wbu_ascii_cmd_decoder.sv
// Bench for wbu_ascii_cmd_decoder: byte table with per-byte error expectations, a command
// scoreboard checked on every handshake, and hand-written overrun and reset sequences.
module tb_wbu_ascii_cmd_decoder;

  logic        clk;
  logic        rst;
  logic        rx_stb;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        err;
  logic        overrun;

  wbu_ascii_cmd_decoder #(.AW(32), .DW(32)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_rx_stb    (rx_stb),
    .i_rx_data   (rx_data),
    .o_cmd_valid (cmd_valid),
    .i_cmd_ready (cmd_ready),
    .o_cmd_we    (cmd_we),
    .o_cmd_addr  (cmd_addr),
    .o_cmd_data  (cmd_data),
    .o_err       (err),
    .o_overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    byte unsigned b;
    bit           err;
    bit           cmd;
    bit           we;
    logic [31:0]  addr;
    logic [31:0]  data;
  } vec_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic q_str(input string s);
    for (int i = 0; i < s.len(); i++)
      vecs.push_back('{b: s[i], err: 1'b0, cmd: 1'b0, we: 1'b0, addr: 32'h0, data: 32'h0});
  endtask

  task automatic q_err(input byte unsigned b);
    vecs.push_back('{b: b, err: 1'b1, cmd: 1'b0, we: 1'b0, addr: 32'h0, data: 32'h0});
  endtask

  task automatic q_cmd(input byte unsigned b, input bit we, input logic [31:0] a,
                       input logic [31:0] d);
    vecs.push_back('{b: b, err: 1'b0, cmd: 1'b1, we: we, addr: a, data: d});
  endtask

  task automatic send_byte(input byte unsigned b);
    @(posedge clk); #1;
    rx_stb  = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_stb  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted command must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_cmd_addr", cmd_addr, 64'hDEAD_0000_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cmd_we", cmd_we, e.we);
        check("cmd_addr", cmd_addr, e.addr);
        if (e.we) check("cmd_data", cmd_data, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    rx_stb    = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b1;

    // Table: one record per received byte, with the error/command it must cause.
    q_str("A20c00");  q_cmd("R", 0, 32'h0002_0C00, 0);
    q_cmd("R", 0, 32'h0002_0C01, 0);
    q_cmd("R", 0, 32'h0002_0C02, 0);
    q_str("A10D1234"); q_cmd("W", 1, 32'h0000_0010, 32'h0000_1234);
    q_str("X");        q_err("R");
    q_str("A1");       q_err("Z");  q_err("R");
    q_str("A1");       q_err("F");  q_err("R");
    q_str("Affffffff"); q_cmd("R", 0, 32'hFFFF_FFFF, 0);
    q_cmd("R", 0, 32'h0000_0000, 0);
    q_err("5");
    q_str("A123456789"); q_cmd("R", 0, 32'h2345_6789, 0);
    q_str("A7D9");     q_cmd("W", 1, 32'h0000_0007, 32'h0000_0009);
    q_cmd("W", 1, 32'h0000_0008, 32'h0000_0009);
    q_str("X");        q_err("D");
    q_str("A3");       q_str("\n"); q_err("R");
    q_str("A4");       vecs.push_back('{b: 8'h0D, err: 1'b0, cmd: 1'b0, we: 1'b0,
                                        addr: 32'h0, data: 32'h0});
    q_err("W");
    q_str("A0Dabcdef01"); q_cmd("W", 1, 32'h0000_0000, 32'hABCD_EF01);

    idle(3);
    rst = 1'b0;
    check("rst_valid", cmd_valid, 0);
    check("rst_we", cmd_we, 0);
    check("rst_addr", cmd_addr, 0);
    check("rst_data", cmd_data, 0);
    check("rst_err", err, 0);
    check("rst_overrun", overrun, 0);

    foreach (vecs[i]) begin
      if (vecs[i].cmd) sb.push_back('{we: vecs[i].we, addr: vecs[i].addr, data: vecs[i].data});
      send_byte(vecs[i].b);
      check($sformatf("err_byte%0d", i), err, vecs[i].err);
      check($sformatf("ovr_byte%0d", i), overrun, 0);
      check($sformatf("valid_byte%0d", i), cmd_valid, vecs[i].cmd);
    end

    // Overrun: first read held while not ready, second 'R' dropped.
    idle(2);
    cmd_ready = 1'b0;
    send_byte("A"); send_byte("5");
    sb.push_back('{we: 1'b0, addr: 32'h5, data: 32'h0});
    send_byte("R");
    check("ovr_first_valid", cmd_valid, 1);
    check("ovr_first_addr", cmd_addr, 32'h5);
    send_byte("R");
    check("ovr_pulse", overrun, 1);
    check("ovr_hold_valid", cmd_valid, 1);
    check("ovr_hold_addr", cmd_addr, 32'h5);
    check("ovr_hold_we", cmd_we, 0);
    idle(1);
    check("ovr_single_pulse", overrun, 0);
    check("ovr_still_held", cmd_addr, 32'h5);
    cmd_ready = 1'b1;
    idle(1);
    check("ovr_valid_drop", cmd_valid, 0);
    idle(2);
    check("ovr_no_addr6", cmd_valid, 0);
    sb.push_back('{we: 1'b0, addr: 32'h7, data: 32'h0});
    send_byte("R");
    check("post_ovr_err", err, 0);

    // Reset with a command pending discards everything.
    idle(2);
    cmd_ready = 1'b0;
    send_byte("A"); send_byte("1"); send_byte("2"); send_byte("R");
    check("pend_valid", cmd_valid, 1);
    check("pend_addr", cmd_addr, 32'h12);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_addr", cmd_addr, 0);
    check("mid_rst_we", cmd_we, 0);
    check("mid_rst_data", cmd_data, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_ovr", overrun, 0);
    cmd_ready = 1'b1;
    send_byte("R");
    check("after_rst_err", err, 1);
    check("after_rst_valid", cmd_valid, 0);
    idle(1);
    check("err_single_pulse", err, 0);

    // Bounded drain of outstanding expected commands.
    for (int c = 0; c < 20 && sb.size() != 0; c++) idle(1);
    check("scoreboard_drained", sb.size(), 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
